lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
Parametrised multi-channel leaky integrate-and-fire neuron bank, the next generation of the single 8-bit leaky neuron.
- NCH independent neurons share one runtime configuration: threshold, refractory length and post-spike reset mode.
- Neurons update only on a timestep strobe. The integrator saturates instead of wrapping.
- Spikes are registered single-cycle pulses, followed by a programmable refractory period.
- Sits between the input current generators and the spike router / event encoder.

Parameters:
NCH, 4, number of neuron channels.
W, 8, membrane state, current and threshold width in bits.
LEAK_SHIFT, 1, leak right-shift applied to state each timestep (1..W-1).
RW, 4, refractory counter width in bits.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-low.
step  input  1  timestep strobe; neurons update only in cycles where step=1.
current  input  NCH*W  per-channel input current, channel i at bits [i*W +: W], unsigned.
cfg_we  input  1  configuration write enable.
cfg_thresh  input  W  threshold value to load.
cfg_refrac  input  RW  refractory length in timesteps to load.
cfg_mode  input  1  post-spike mode: 0 = reset to zero, 1 = subtract threshold.
spike  output  NCH  registered per-channel spike pulse.
state  output  NCH*W  registered membrane state per channel, same packing as current.
refractory  output  NCH  1 while the channel's refractory counter is nonzero.

Behaviour:
Reset, rst=0 at a clk edge, overrides everything including step and cfg_we:
- state=0, spike=0, refractory counters=0.
- thresh=2^(W-1)-1 (127 for W=8), refrac_len=0, mode=0.

Config registers:
- On cfg_we=1, thresh, refrac_len and mode load at the clk edge.
- If cfg_we and step are both 1 in the same cycle, that step uses the old config.

step=0:
- state and refractory counters hold.
- spike=0 (spike is a 1-cycle pulse, never held).

step=1, per channel i, independently:
- Refractory (cnt_i != 0):
  - cnt_i <= cnt_i-1, state_i <= 0, spike_i <= 0.
  - current_i is ignored.
- Otherwise integrate: sum = current_i + (state_i >> LEAK_SHIFT), computed at W+1 bits.
  - nxt = min(sum, 2^W-1), i.e. saturating.
  - If nxt >= thresh:
    - spike_i <= 1, cnt_i <= refrac_len.
    - state_i <= 0 when mode=0, or nxt - thresh when mode=1.
  - Else: spike_i <= 0, state_i <= nxt.
- Latency: spike asserts in the cycle after the step edge that evaluated the crossing. It is computed on the new value, not the old state.
- refrac_len=0: no refractory. The channel can spike on consecutive steps.
- thresh=0: every non-refractory step spikes.
  - mode=1 then leaves state=nxt.
- Saturation applies before the threshold compare.
  - Mode-1 subtraction cannot underflow, since nxt >= thresh.
- refractory_i = (cnt_i != 0), registered with the counter.
- A channel becomes refractory in the same cycle its spike is output.
- Config changes do not alter an in-progress refractory count. The new refrac_len applies from the next spike.
- Reset mid-refractory clears the counter immediately; the next step integrates.
- No combinational path from any input to any output.

Test Plan:
1. Reset and defaults (W=8, LEAK_SHIFT=1), with step=1 and current=200 on all channels during reset:
   - all outputs must read 0.
   - After release, the first step spikes each channel, since 200 >= 127.
2. Leak integration, ch0 only:
   - current=40 each step, thresh=127, mode=0, refrac=0.
   - state sequence 40, 60, 70, 75, 77, 78, 79, 79.
   - Never spikes, and spike stays 0 between steps.
3. Saturation and mode 1:
   - With state=200, step with current=250, thresh=100, mode=1 → spike=1, state=155 (255-100).
4. Refractory:
   - refrac=3, thresh=50, constant current=60 → spike on step 1.
   - refractory=1 and state=0 for steps 2-4; spike again on step 5.
5. Config/step collision and independence:
   - cfg_we with thresh=10 in the same cycle as step with current=20 → no spike that step (old thresh 127).
   - Next step spikes.
   - Meanwhile ch1 with current=0 stays at 0 and never spikes.
6. Reset mid-refractory:
   - refrac=15, force a spike, assert rst one cycle → counter and refractory clear.
   - Next step with current=130 spikes.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Bank of NCH leaky integrate-and-fire neurons sharing one threshold/refractory/mode
// configuration; every channel advances only on the timestep strobe.
module lif_neuron_array #(
    parameter int NCH        = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int RW         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [NCH*W-1:0] current,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_thresh,
    input  logic [RW-1:0]    cfg_refrac,
    input  logic             cfg_mode,
    output logic [NCH-1:0]   spike,
    output logic [NCH*W-1:0] state,
    output logic [NCH-1:0]   refractory
);

    logic [W-1:0]  thresh_q;
    logic [RW-1:0] refrac_len_q;
    logic          mode_q;

    // Shared config; a step in the same cycle as a write still sees the old values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            thresh_q     <= {1'b0, {(W-1){1'b1}}};
            refrac_len_q <= '0;
            mode_q       <= 1'b0;
        end else if (cfg_we) begin
            thresh_q     <= cfg_thresh;
            refrac_len_q <= cfg_refrac;
            mode_q       <= cfg_mode;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0]  st_q;
        logic [W-1:0]  cur;
        logic [W:0]    sum;
        logic [W-1:0]  nxt;
        logic [RW-1:0] cnt_q;
        logic          spk_q;

        assign cur = current[i*W +: W];
        assign sum = {1'b0, cur} + {1'b0, st_q >> LEAK_SHIFT};
        assign nxt = sum[W] ? {W{1'b1}} : sum[W-1:0];

        always_ff @(posedge clk) begin
            if (!rst) begin
                st_q  <= '0;
                cnt_q <= '0;
                spk_q <= 1'b0;
            end else begin
                spk_q <= 1'b0;
                if (step) begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - RW'(1);
                        st_q  <= '0;
                    end else if (nxt >= thresh_q) begin
                        spk_q <= 1'b1;
                        cnt_q <= refrac_len_q;
                        st_q  <= mode_q ? (nxt - thresh_q) : '0;
                    end else begin
                        st_q  <= nxt;
                    end
                end
            end
        end

        assign spike[i]          = spk_q;
        assign state[i*W +: W]   = st_q;
        assign refractory[i]     = (cnt_q != '0);
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed vector table plus randomized
// traffic, both compared every cycle against an arithmetic reference model.
module tb_lif_neuron_array;
    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int LS  = 1;
    localparam int RW  = 4;
    localparam int MAXV = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             step;
    logic [NCH*W-1:0] current;
    logic             cfg_we;
    logic [W-1:0]     cfg_thresh;
    logic [RW-1:0]    cfg_refrac;
    logic             cfg_mode;
    logic [NCH-1:0]   spike;
    logic [NCH*W-1:0] state;
    logic [NCH-1:0]   refractory;

    lif_neuron_array #(.NCH(NCH), .W(W), .LEAK_SHIFT(LS), .RW(RW)) dut (
        .clk(clk), .rst(rst), .step(step), .current(current),
        .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .cfg_refrac(cfg_refrac),
        .cfg_mode(cfg_mode), .spike(spike), .state(state), .refractory(refractory)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int m_state [NCH];
    int m_cnt   [NCH];
    int m_spike [NCH];
    int m_th, m_rl, m_md;

    typedef struct {
        bit rst, step, we;
        int th, rf, md, c0, c1;
        bit chk;
        int s0, k0, r0, s1, k1;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_edge();
        int cur, nxt;
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_state[c] = 0; m_cnt[c] = 0; m_spike[c] = 0;
            end
            m_th = (1 << (W-1)) - 1; m_rl = 0; m_md = 0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            m_spike[c] = 0;
            if (step) begin
                if (m_cnt[c] > 0) begin
                    m_cnt[c]--;
                    m_state[c] = 0;
                end else begin
                    cur = int'(current[c*W +: W]);
                    nxt = cur + m_state[c] / (1 << LS);
                    if (nxt > MAXV) nxt = MAXV;
                    if (nxt >= m_th) begin
                        m_spike[c] = 1;
                        m_cnt[c]   = m_rl;
                        m_state[c] = m_md ? nxt - m_th : 0;
                    end else begin
                        m_state[c] = nxt;
                    end
                end
            end
        end
        if (cfg_we) begin
            m_th = int'(cfg_thresh); m_rl = int'(cfg_refrac); m_md = int'(cfg_mode);
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("model_state[%0d]", c), int'(state[c*W +: W]), m_state[c]);
            check($sformatf("model_spike[%0d]", c), int'(spike[c]), m_spike[c]);
            check($sformatf("model_refr[%0d]", c), int'(refractory[c]), (m_cnt[c] != 0) ? 1 : 0);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        rst = v.rst; step = v.step; cfg_we = v.we;
        cfg_thresh = W'(v.th); cfg_refrac = RW'(v.rf); cfg_mode = v.md[0];
        current = {W'(v.c0), W'(v.c0), W'(v.c1), W'(v.c0)};
        cycle();
        if (v.chk) begin
            check($sformatf("v%0d_state0", idx), int'(state[0 +: W]), v.s0);
            check($sformatf("v%0d_spike0", idx), int'(spike[0]), v.k0);
            check($sformatf("v%0d_refr0", idx), int'(refractory[0]), v.r0);
            check($sformatf("v%0d_state1", idx), int'(state[W +: W]), v.s1);
            check($sformatf("v%0d_spike1", idx), int'(spike[1]), v.k1);
        end
    endtask

    initial begin
        rst = 1'b0; step = 1'b0; cfg_we = 1'b0; cfg_thresh = '0;
        cfg_refrac = '0; cfg_mode = 1'b0; current = '0;

        //           rst step we  th  rf md  c0  c1 chk  s0  k0 r0  s1 k1
        // reset with step and current active, then first step spikes at 127
        tbl.push_back('{0,1,0,   0, 0,0, 200,200, 1,   0, 0,0,   0,0});
        tbl.push_back('{0,1,0,   0, 0,0, 200,200, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0, 200,200, 1,   0, 1,0,   0,1});
        tbl.push_back('{1,0,0,   0, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        // leak integration on ch0, idle cycles hold state with spike low
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  40, 0,0,   0,0});
        tbl.push_back('{1,0,0,   0, 0,0,  40,  0, 1,  40, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  60, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  70, 0,0,   0,0});
        tbl.push_back('{1,0,0,   0, 0,0,  40,  0, 1,  70, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  75, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  77, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  78, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  79, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  40,  0, 1,  79, 0,0,   0,0});
        // saturation then mode-1 subtraction: 200 + 250 -> 255 - 100
        tbl.push_back('{0,0,0,   0, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,0,1, 255, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0, 200,  0, 1, 200, 0,0,   0,0});
        tbl.push_back('{1,0,1, 100, 0,1,   0,  0, 1, 200, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0, 250,  0, 1, 155, 1,0,   0,0});
        // refractory of 3 steps
        tbl.push_back('{0,0,0,   0, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,0,1,  50, 3,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  60,  0, 1,   0, 1,1,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  60,  0, 1,   0, 0,1,   0,0});
        tbl.push_back('{1,0,0,   0, 0,0,  60,  0, 1,   0, 0,1,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  60,  0, 1,   0, 0,1,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  60,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  60,  0, 1,   0, 1,1,   0,0});
        // config write colliding with a step uses the old threshold
        tbl.push_back('{0,0,0,   0, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,1,  10, 0,0,  20,  0, 1,  20, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,  20,  0, 1,   0, 1,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        // reset in the middle of a long refractory period
        tbl.push_back('{1,0,1, 127,15,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0, 130,  0, 1,   0, 1,1,   0,0});
        tbl.push_back('{1,0,0,   0, 0,0,   0,  0, 1,   0, 0,1,   0,0});
        tbl.push_back('{0,0,0,   0, 0,0,   0,  0, 1,   0, 0,0,   0,0});
        tbl.push_back('{1,1,0,   0, 0,0, 130,  0, 1,   0, 1,0,   0,0});

        foreach (tbl[i]) apply_vec(tbl[i], i);

        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 59) != 0);
            step   = ($urandom_range(0, 9) < 6);
            cfg_we = ($urandom_range(0, 11) == 0);
            cfg_thresh = W'($urandom_range(0, MAXV));
            cfg_refrac = RW'($urandom_range(0, (1 << RW) - 1));
            cfg_mode   = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++)
                current[c*W +: W] = W'($urandom_range(0, MAXV));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
